// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron tile: default counter width,
// decoder state encoding and a width-agnostic saturating increment.
package lif_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Callers pass their own ceiling so one function serves every counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Registers a spike line and flags its rising edge, so a level held high
// for many cycles is seen as a single event.
module spike_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_i,
  output logic rise_o
);

  logic spike_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_i;
    end
  end

  assign rise_o = spike_i & ~spike_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a spike train into a per-window rising-edge count (rate) and the
// most recent inter-spike interval (isi); every output is a register.
module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             spike,
  input  logic [CNT_W-1:0] win_len,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(32'(v), 32'(CNT_MAX)));
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic [CNT_W-1:0] isi_tmr_q, isi_tmr_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic [CNT_W-1:0] isi_q, isi_d;
  logic             rate_vld_q, rate_vld_d;
  logic             isi_vld_q, isi_vld_d;
  logic             spk_edge;
  logic [CNT_W-1:0] spk_inc;

  spike_edge_det u_edge (
    .clk     (clk),
    .rst_n   (reset_n),
    .spike_i (spike),
    .rise_o  (spk_edge)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      spk_cnt_q  <= '0;
      isi_tmr_q  <= '0;
      seen_q     <= 1'b0;
      rate_q     <= '0;
      isi_q      <= '0;
      rate_vld_q <= 1'b0;
      isi_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      spk_cnt_q  <= spk_cnt_d;
      isi_tmr_q  <= isi_tmr_d;
      seen_q     <= seen_d;
      rate_q     <= rate_d;
      isi_q      <= isi_d;
      rate_vld_q <= rate_vld_d;
      isi_vld_q  <= isi_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    spk_cnt_d  = spk_cnt_q;
    isi_tmr_d  = isi_tmr_q;
    seen_d     = seen_q;
    rate_d     = rate_q;
    isi_d      = isi_q;
    rate_vld_d = 1'b0;
    isi_vld_d  = 1'b0;
    spk_inc    = spk_edge ? inc_sat(spk_cnt_q) : spk_cnt_q;

    unique case (state_q)
      IDLE: begin
        spk_cnt_d = '0;
        isi_tmr_d = '0;
        seen_d    = 1'b0;
        if (en) begin
          // win_len of zero wraps to the all-ones count, i.e. 2^CNT_W cycles.
          win_cnt_d = win_len - CNT_W'(1);
          state_d   = COUNT;
        end
      end

      COUNT: begin
        if (!en) begin
          state_d   = IDLE;
          spk_cnt_d = '0;
          isi_tmr_d = '0;
          seen_d    = 1'b0;
        end else begin
          if (win_cnt_q == '0) begin
            rate_d     = spk_inc;
            rate_vld_d = 1'b1;
            spk_cnt_d  = '0;
            win_cnt_d  = win_len - CNT_W'(1);
          end else begin
            win_cnt_d  = win_cnt_q - CNT_W'(1);
            spk_cnt_d  = spk_inc;
          end

          // The first edge after enabling only arms the interval timer.
          if (spk_edge) begin
            isi_tmr_d = CNT_W'(1);
            seen_d    = 1'b1;
            if (seen_q) begin
              isi_d     = isi_tmr_q;
              isi_vld_d = 1'b1;
            end
          end else begin
            isi_tmr_d = inc_sat(isi_tmr_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rate       = rate_q;
  assign rate_valid = rate_vld_q;
  assign isi        = isi_q;
  assign isi_valid  = isi_vld_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: directed spike patterns push
// hand-computed rate/isi results, a negedge monitor pops and compares.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       spike;
  logic [7:0] win_len;
  logic [7:0] rate;
  logic       rate_valid;
  logic [7:0] isi;
  logic       isi_valid;

  spike_rate_decoder #(.CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .spike      (spike),
    .win_len    (win_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .isi        (isi),
    .isi_valid  (isi_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int at;
  } exp_t;

  exp_t rate_exp[$];
  int   isi_exp[$];
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  int   mon_i;
  int   s;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic sp, input logic e, input logic [7:0] w);
    spike   = sp;
    en      = e;
    win_len = w;
    @(posedge clk);
    #1;
  endtask

  task automatic push_rate(input int v, input int at);
    exp_t e;
    e.val = v;
    e.at  = at;
    rate_exp.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (rate_valid) begin
        if (rate_exp.size() == 0) begin
          chk("unexpected rate_valid", 1, 0);
        end else begin
          mon_e = rate_exp.pop_front();
          chk("rate value", int'(rate), mon_e.val);
          chk("rate_valid cycle", cyc, mon_e.at);
        end
      end
      if (isi_valid) begin
        if (isi_exp.size() == 0) begin
          chk("unexpected isi_valid", 1, 0);
        end else begin
          mon_i = isi_exp.pop_front();
          chk("isi value", int'(isi), mon_i);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    spike   = 1'b0;
    win_len = 8'd10;
    repeat (3) drive(1'b0, 1'b0, 8'd10);
    chk("reset rate", int'(rate), 0);
    chk("reset isi", int'(isi), 0);
    chk("reset rate_valid", int'(rate_valid), 0);
    chk("reset isi_valid", int'(isi_valid), 0);
    reset_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'd10);

    // Reset in the middle of a 20-cycle window after five edges.
    repeat (4) isi_exp.push_back(2);
    for (int p = 0; p <= 10; p++) drive((p % 2) == 1, 1'b1, 8'd20);
    reset_n = 1'b0;
    en      = 1'b0;
    #1;
    chk("mid-window reset rate", int'(rate), 0);
    chk("mid-window reset isi", int'(isi), 0);
    chk("mid-window reset rate_valid", int'(rate_valid), 0);
    chk("mid-window reset isi_valid", int'(isi_valid), 0);
    repeat (3) drive(1'b0, 1'b0, 8'd20);
    reset_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'd10);
    chk("rate after reset release", int'(rate), 0);

    // Three one-cycle spikes in a 10-cycle window, then an empty window.
    s = cyc;
    push_rate(3, s + 11);
    push_rate(0, s + 21);
    isi_exp.push_back(3);
    isi_exp.push_back(4);
    for (int p = 0; p <= 21; p++) drive(p == 2 || p == 5 || p == 9, p <= 20, 8'd10);
    repeat (3) drive(1'b0, 1'b0, 8'd10);

    // Spike held high for 20 cycles yields a single edge.
    s = cyc;
    push_rate(1, s + 11);
    push_rate(0, s + 21);
    for (int p = 0; p <= 21; p++) drive(p >= 1 && p <= 20, p <= 20, 8'd10);
    repeat (3) drive(1'b0, 1'b0, 8'd10);

    // Intervals of 7 and 300 cycles inside 256-cycle windows.
    s = cyc;
    push_rate(2, s + 257);
    isi_exp.push_back(7);
    isi_exp.push_back(255);
    for (int p = 0; p <= 310; p++) drive(p == 1 || p == 8 || p == 308, p < 310, 8'd0);
    repeat (3) drive(1'b0, 1'b0, 8'd0);

    // Alternating spikes in a 256-cycle window, win_len switched to 4
    // mid-window, an edge on a window's last cycle, then en dropped mid-window.
    s = cyc;
    push_rate(128, s + 257);
    push_rate(2, s + 261);
    push_rate(1, s + 265);
    repeat (129) isi_exp.push_back(2);
    isi_exp.push_back(5);
    isi_exp.push_back(2);
    for (int p = 0; p <= 268; p++)
      drive((p >= 1 && p <= 259 && (p % 2) == 1) || p == 264 || p == 266,
            p < 267, (p < 100) ? 8'd0 : 8'd4);
    repeat (5) drive(1'b0, 1'b0, 8'd4);
    chk("rate holds after en drop", int'(rate), 1);

    chk("rate scoreboard drained", rate_exp.size(), 0);
    chk("isi scoreboard drained", isi_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
